// File: rtl/hbm_rd_req_gen.sv
// HBM AXI3 read-address generator.
// Streams the b (label) region and then the a (feature) region as fixed-length INCR
// bursts for each epoch. The number of bursts in flight is capped by counting RLAST
// completions observed on the R channel.

`ifndef MEM_RD_A_TAG
`define MEM_RD_A_TAG 6'd1
`endif
`ifndef MEM_RD_B_TAG
`define MEM_RD_B_TAG 6'd2
`endif

module hbm_rd_req_gen #(
    parameter int                    ADDR_WIDTH      = 33,
    parameter int                    ID_WIDTH        = 6,
    parameter int                    BURST_LEN       = 8,
    parameter int                    MAX_OUTSTANDING = 16,
    parameter logic [ID_WIDTH-1:0]   A_TAG           = `MEM_RD_A_TAG,
    parameter logic [ID_WIDTH-1:0]   B_TAG           = `MEM_RD_B_TAG
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [ADDR_WIDTH-1:0]  addr_a,
    input  logic [ADDR_WIDTH-1:0]  addr_b,
    input  logic [31:0]            data_length,
    input  logic [31:0]            b_length,
    input  logic [31:0]            num_epochs,
    output logic                   m_axi_ARVALID,
    input  logic                   m_axi_ARREADY,
    output logic [ADDR_WIDTH-1:0]  m_axi_ARADDR,
    output logic [ID_WIDTH-1:0]    m_axi_ARID,
    output logic [3:0]             m_axi_ARLEN,
    output logic [2:0]             m_axi_ARSIZE,
    output logic [1:0]             m_axi_ARBURST,
    input  logic                   m_axi_RVALID,
    input  logic                   m_axi_RREADY,
    input  logic                   m_axi_RLAST,
    output logic                   busy,
    output logic                   done,
    output logic [31:0]            ar_a_counter,
    output logic [31:0]            ar_b_counter,
    output logic [31:0]            epoch_counter,
    output logic [7:0]             outstanding
);

    localparam int                    BURST_BYTES = 32 * BURST_LEN;
    localparam int                    ALIGN_BITS  = $clog2(BURST_BYTES);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK  = {{(ADDR_WIDTH-ALIGN_BITS){1'b1}}, {ALIGN_BITS{1'b0}}};
    localparam logic [ADDR_WIDTH-1:0] STEP        = ADDR_WIDTH'(BURST_BYTES);
    localparam logic [32:0]           BB33        = 33'(BURST_BYTES);
    localparam logic [7:0]            MAX_OUT     = 8'(MAX_OUTSTANDING);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE_B = 3'd1,
        S_ISSUE_A = 3'd2,
        S_DRAIN   = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t                  r_state;
    logic                    r_arvalid;
    logic [ADDR_WIDTH-1:0]   r_araddr;
    logic [ID_WIDTH-1:0]     r_arid;
    logic [ADDR_WIDTH-1:0]   r_base_a;
    logic [ADDR_WIDTH-1:0]   r_base_b;
    logic [31:0]             r_na;
    logic [31:0]             r_nb;
    logic [31:0]             r_epochs;
    logic [31:0]             r_idx;
    logic [31:0]             r_ar_a_cnt;
    logic [31:0]             r_ar_b_cnt;
    logic [31:0]             r_epoch_cnt;
    logic [7:0]              r_outstanding;
    logic                    r_busy;
    logic                    r_done;

    logic                    w_hs;
    logic                    w_rlast;
    logic [7:0]              w_out_next;
    logic                    w_credit_ok;
    logic [31:0]             w_na_in;
    logic [31:0]             w_nb_in;
    logic [ADDR_WIDTH-1:0]   w_base_a_in;
    logic [ADDR_WIDTH-1:0]   w_base_b_in;
    logic [31:0]             w_region_cnt;
    logic                    w_last_in_region;
    logic                    w_more_epochs;

    // Burst counts per region, rounded up to whole bursts.
    assign w_na_in     = 32'((({1'b0, data_length} + BB33 - 33'd1) / BB33));
    assign w_nb_in     = 32'((({1'b0, b_length}    + BB33 - 33'd1) / BB33));
    assign w_base_a_in = addr_a & ALIGN_MASK;
    assign w_base_b_in = addr_b & ALIGN_MASK;

    assign w_hs    = r_arvalid & m_axi_ARREADY;
    // A completion with nothing in flight is spurious and must not underflow the count.
    assign w_rlast = m_axi_RVALID & m_axi_RREADY & m_axi_RLAST & (r_outstanding != 8'd0);

    assign w_region_cnt     = (r_state == S_ISSUE_B) ? r_nb : r_na;
    assign w_last_in_region = (r_idx == (w_region_cnt - 32'd1));
    assign w_more_epochs    = (({1'b0, r_epoch_cnt} + 33'd1) < {1'b0, r_epochs});

    // Next-cycle in-flight count; ARVALID for the next cycle is gated on it so that
    // whenever ARVALID is high the registered count is below the cap.
    always_comb begin
        w_out_next = r_outstanding;
        if (w_hs && !w_rlast) begin
            w_out_next = r_outstanding + 8'd1;
        end else if (!w_hs && w_rlast) begin
            w_out_next = r_outstanding - 8'd1;
        end
    end

    assign w_credit_ok = (w_out_next < MAX_OUT);

    // In-flight burst counter: +1 per AR handshake, -1 per observed RLAST.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_outstanding <= 8'd0;
        end else begin
            r_outstanding <= w_out_next;
        end
    end

    // Sequencing FSM: latches the job, walks b then a bursts per epoch, drains, reports.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_arvalid   <= 1'b0;
            r_araddr    <= '0;
            r_arid      <= '0;
            r_base_a    <= '0;
            r_base_b    <= '0;
            r_na        <= 32'd0;
            r_nb        <= 32'd0;
            r_epochs    <= 32'd0;
            r_idx       <= 32'd0;
            r_ar_a_cnt  <= 32'd0;
            r_ar_b_cnt  <= 32'd0;
            r_epoch_cnt <= 32'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_base_a    <= w_base_a_in;
                        r_base_b    <= w_base_b_in;
                        r_na        <= w_na_in;
                        r_nb        <= w_nb_in;
                        r_epochs    <= (num_epochs == 32'd0) ? 32'd1 : num_epochs;
                        r_idx       <= 32'd0;
                        r_ar_a_cnt  <= 32'd0;
                        r_ar_b_cnt  <= 32'd0;
                        r_epoch_cnt <= 32'd0;
                        if (w_nb_in != 32'd0) begin
                            r_state   <= S_ISSUE_B;
                            r_araddr  <= w_base_b_in;
                            r_arid    <= B_TAG;
                            r_arvalid <= w_credit_ok;
                            r_busy    <= 1'b1;
                        end else if (w_na_in != 32'd0) begin
                            r_state   <= S_ISSUE_A;
                            r_araddr  <= w_base_a_in;
                            r_arid    <= A_TAG;
                            r_arvalid <= w_credit_ok;
                            r_busy    <= 1'b1;
                        end else begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end

                S_ISSUE_B, S_ISSUE_A: begin
                    if (w_hs) begin
                        if (r_state == S_ISSUE_B) begin
                            r_ar_b_cnt <= r_ar_b_cnt + 32'd1;
                        end else begin
                            r_ar_a_cnt <= r_ar_a_cnt + 32'd1;
                        end
                        if (w_last_in_region) begin
                            r_idx <= 32'd0;
                            if ((r_state == S_ISSUE_B) && (r_na != 32'd0)) begin
                                r_state   <= S_ISSUE_A;
                                r_araddr  <= r_base_a;
                                r_arid    <= A_TAG;
                                r_arvalid <= w_credit_ok;
                            end else begin
                                // Epoch ends on its final burst (the a region, or b if a is empty).
                                r_epoch_cnt <= r_epoch_cnt + 32'd1;
                                if (w_more_epochs) begin
                                    if (r_nb != 32'd0) begin
                                        r_state  <= S_ISSUE_B;
                                        r_araddr <= r_base_b;
                                        r_arid   <= B_TAG;
                                    end else begin
                                        r_state  <= S_ISSUE_A;
                                        r_araddr <= r_base_a;
                                        r_arid   <= A_TAG;
                                    end
                                    r_arvalid <= w_credit_ok;
                                end else begin
                                    r_state   <= S_DRAIN;
                                    r_arvalid <= 1'b0;
                                end
                            end
                        end else begin
                            r_idx     <= r_idx + 32'd1;
                            r_araddr  <= r_araddr + STEP;
                            r_arvalid <= w_credit_ok;
                        end
                    end else begin
                        // No handshake: the count cannot rise, so a raised ARVALID stays up.
                        r_arvalid <= w_credit_ok;
                    end
                end

                S_DRAIN: begin
                    if (r_outstanding == 8'd0) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign m_axi_ARVALID = r_arvalid;
    assign m_axi_ARADDR  = r_araddr;
    assign m_axi_ARID    = r_arid;
    assign m_axi_ARLEN   = 4'(BURST_LEN - 1);
    assign m_axi_ARSIZE  = 3'b101;
    assign m_axi_ARBURST = 2'b01;
    assign busy          = r_busy;
    assign done          = r_done;
    assign ar_a_counter  = r_ar_a_cnt;
    assign ar_b_counter  = r_ar_b_cnt;
    assign epoch_counter = r_epoch_cnt;
    assign outstanding   = r_outstanding;

endmodule

// File: tb/tb_hbm_rd_req_gen.sv
// Testbench for hbm_rd_req_gen: table-driven jobs, randomized jobs and hand-written
// corner sequences, all checked against an address-list scoreboard and a credit model.
module tb_hbm_rd_req_gen;

    localparam int          AW   = 33;
    localparam int          IW   = 6;
    localparam int          BL   = 8;
    localparam int          MAXO = 4;
    localparam int          BB   = 32 * BL;
    localparam logic [5:0]  A_T  = 6'h0A;
    localparam logic [5:0]  B_T  = 6'h0B;

    logic           clk;
    logic           rst;
    logic           start;
    logic [AW-1:0]  addr_a;
    logic [AW-1:0]  addr_b;
    logic [31:0]    data_length;
    logic [31:0]    b_length;
    logic [31:0]    num_epochs;
    logic           ARVALID;
    logic           ARREADY;
    logic [AW-1:0]  ARADDR;
    logic [IW-1:0]  ARID;
    logic [3:0]     ARLEN;
    logic [2:0]     ARSIZE;
    logic [1:0]     ARBURST;
    logic           RVALID;
    logic           RREADY;
    logic           RLAST;
    logic           busy;
    logic           done;
    logic [31:0]    ar_a_counter;
    logic [31:0]    ar_b_counter;
    logic [31:0]    epoch_counter;
    logic [7:0]     outstanding;

    hbm_rd_req_gen #(
        .ADDR_WIDTH(AW), .ID_WIDTH(IW), .BURST_LEN(BL), .MAX_OUTSTANDING(MAXO),
        .A_TAG(A_T), .B_TAG(B_T)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .addr_a(addr_a), .addr_b(addr_b),
        .data_length(data_length), .b_length(b_length), .num_epochs(num_epochs),
        .m_axi_ARVALID(ARVALID), .m_axi_ARREADY(ARREADY), .m_axi_ARADDR(ARADDR),
        .m_axi_ARID(ARID), .m_axi_ARLEN(ARLEN), .m_axi_ARSIZE(ARSIZE), .m_axi_ARBURST(ARBURST),
        .m_axi_RVALID(RVALID), .m_axi_RREADY(RREADY), .m_axi_RLAST(RLAST),
        .busy(busy), .done(done),
        .ar_a_counter(ar_a_counter), .ar_b_counter(ar_b_counter),
        .epoch_counter(epoch_counter), .outstanding(outstanding)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [32:0] addr;
        logic [5:0]  id;
    } ar_t;

    typedef struct {
        logic [32:0] aa;
        logic [32:0] ab;
        int unsigned dl;
        int unsigned bl;
        int unsigned ep;
        int          mode;
        int          lat;
        int          ea;
        int          eb;
        int          ee;
    } vec_t;

    // Expected AR sequence for the current job (written by the test, read by the monitor).
    ar_t exp_q[$];
    int  n_checks = 0;
    int  n_pass   = 0;

    // Test-owned controls.
    int  rmode      = 0;   // 0: ready=1, 1: 1-0-0-1 pattern, 2: random, 3: ready=0
    int  rlat       = 4;
    bit  resp_en    = 1'b1;
    bit  noise      = 1'b0;
    int  manual_req = 0;

    // Monitor-owned state.
    int          manual_done = 0;
    longint      cyc         = 0;
    longint      rq[$];
    int          model_out   = 0;
    int          sb_idx      = 0;
    int          done_cnt    = 0;
    bit          prev_stall  = 1'b0;
    logic [32:0] prev_addr   = '0;
    logic [5:0]  prev_id     = '0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference: the AR list is every epoch's b bursts then a bursts, from aligned bases.
    task automatic build_exp(input logic [32:0] aa, input logic [32:0] ab,
                             input int unsigned dl, input int unsigned bl, input int unsigned ep);
        longint      na;
        longint      nb;
        longint      eff;
        logic [32:0] base_a;
        logic [32:0] base_b;
        ar_t         e;
        exp_q.delete();
        na     = (longint'(dl) + BB - 1) / BB;
        nb     = (longint'(bl) + BB - 1) / BB;
        eff    = (ep == 0) ? 1 : longint'(ep);
        base_a = aa & ~33'(BB - 1);
        base_b = ab & ~33'(BB - 1);
        if (na + nb > 0) begin
            for (longint en = 0; en < eff; en++) begin
                for (longint k = 0; k < nb; k++) begin
                    e.addr = base_b + 33'(k * BB);
                    e.id   = B_T;
                    exp_q.push_back(e);
                end
                for (longint k = 0; k < na; k++) begin
                    e.addr = base_a + 33'(k * BB);
                    e.id   = A_T;
                    exp_q.push_back(e);
                end
            end
        end
    endtask

    // Monitor (negedge) and AR-ready / R-channel driver (posedge+1) in one process.
    initial begin
        bit hs;
        bit rl;
        ARREADY = 1'b0; RVALID = 1'b0; RREADY = 1'b0; RLAST = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                model_out  = 0;
                rq.delete();
                sb_idx     = 0;
                prev_stall = 1'b0;
            end else begin
                if (start && !busy) begin
                    sb_idx   = 0;
                    done_cnt = 0;
                end
                if (done) done_cnt++;
                chk("outstanding", longint'(outstanding), longint'(model_out));
                if (ARVALID) chk("credit_gate", longint'(model_out < MAXO), 1);
                if (prev_stall) begin
                    chk("hold_valid", longint'(ARVALID), 1);
                    chk("hold_addr", longint'(ARADDR), longint'(prev_addr));
                    chk("hold_id", longint'(ARID), longint'(prev_id));
                end
                hs = ARVALID && ARREADY;
                rl = RVALID && RREADY && RLAST;
                if (hs) begin
                    if (sb_idx < exp_q.size()) begin
                        chk("ar_addr", longint'(ARADDR), longint'(exp_q[sb_idx].addr));
                        chk("ar_id", longint'(ARID), longint'(exp_q[sb_idx].id));
                    end else begin
                        chk("ar_unexpected", longint'(sb_idx), longint'(exp_q.size()));
                    end
                    sb_idx++;
                    rq.push_back(cyc + rlat);
                end
                if (rl && model_out > 0) model_out--;
                if (hs) model_out++;
                prev_stall = ARVALID && !ARREADY;
                prev_addr  = ARADDR;
                prev_id    = ARID;
            end
            @(posedge clk);
            cyc++;
            #1;
            case (rmode)
                0:       ARREADY = 1'b1;
                1:       ARREADY = ((cyc % 4) == 0) || ((cyc % 4) == 3);
                2:       ARREADY = 1'($urandom_range(0, 1));
                default: ARREADY = 1'b0;
            endcase
            RVALID = 1'b0; RREADY = 1'b0; RLAST = 1'b0;
            if (manual_done < manual_req) begin
                RVALID = 1'b1; RREADY = 1'b1; RLAST = 1'b1;
                manual_done++;
            end else if (resp_en && rq.size() > 0 && rq[0] <= cyc) begin
                void'(rq.pop_front());
                RVALID = 1'b1; RREADY = 1'b1; RLAST = 1'b1;
            end else if (noise) begin
                RVALID = 1'b1;
                RREADY = 1'($urandom_range(0, 1));
                RLAST  = !RREADY;
            end
        end
    end

    task automatic do_start(input logic [32:0] aa, input logic [32:0] ab,
                            input int unsigned dl, input int unsigned bl, input int unsigned ep);
        @(posedge clk); #2;
        addr_a = aa; addr_b = ab; data_length = dl; b_length = bl; num_epochs = ep;
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, input string name);
        bit got;
        got = 1'b0;
        for (int i = 0; i < limit && !got; i++) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
        chk({name, "_done_seen"}, longint'(got), 1);
    endtask

    task automatic run_cfg(input string name, input logic [32:0] aa, input logic [32:0] ab,
                           input int unsigned dl, input int unsigned bl, input int unsigned ep,
                           input int mode, input int lat, input int ea, input int eb, input int ee);
        build_exp(aa, ab, dl, bl, ep);
        rmode   = mode;
        rlat    = lat;
        resp_en = 1'b1;
        do_start(aa, ab, dl, bl, ep);
        wait_done(4000, name);
        chk({name, "_out_at_done"}, longint'(outstanding), 0);
        chk({name, "_busy_at_done"}, longint'(busy), 0);
        chk({name, "_a_cnt"}, longint'(ar_a_counter), longint'(ea));
        chk({name, "_b_cnt"}, longint'(ar_b_counter), longint'(eb));
        chk({name, "_epochs"}, longint'(epoch_counter), longint'(ee));
        repeat (3) @(negedge clk);
        chk({name, "_done_pulses"}, longint'(done_cnt), 1);
        chk({name, "_ar_total"}, longint'(sb_idx), longint'(exp_q.size()));
        $display("job %s: a=%0d b=%0d epochs=%0d bursts=%0d", name, ar_a_counter, ar_b_counter,
                 epoch_counter, sb_idx);
    endtask

    // Global bound so the run always terminates.
    initial begin
        #900000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t        vt[6];
        logic [32:0] ra;
        logic [32:0] rb;
        int unsigned rdl;
        int unsigned rbl;
        int unsigned rep;
        int          reff;
        int          rna;
        int          rnb;
        bit          reached;

        vt[0] = '{33'h8000, 33'h1000, 1024, 512, 1, 0, 4, 4, 2, 1};          // basic ordering
        vt[1] = '{33'h4000, 33'h2000, 300, 0, 1, 0, 3, 2, 0, 1};             // rounding, no b
        vt[2] = '{33'h4000, 33'h2000, 0, 0, 1, 0, 3, 0, 0, 0};               // both zero
        vt[3] = '{33'h30000, 33'h10000, 512, 100, 3, 1, 2, 6, 3, 3};         // 3 epochs, backpressure
        vt[4] = '{33'h5000, 33'h6000, 256, 257, 0, 2, 5, 1, 2, 1};           // epochs=0, exact/over boundary
        vt[5] = '{33'h1_FFFF_FF10, 33'h0_0000_0777, 768, 1, 1, 1, 1, 3, 1, 1}; // misaligned, wrap

        rst = 1'b1; start = 1'b0;
        addr_a = '0; addr_b = '0; data_length = 0; b_length = 0; num_epochs = 0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("rst_arvalid", longint'(ARVALID), 0);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_done", longint'(done), 0);
        chk("rst_outstanding", longint'(outstanding), 0);
        chk("rst_a_cnt", longint'(ar_a_counter), 0);
        chk("rst_b_cnt", longint'(ar_b_counter), 0);
        chk("rst_epochs", longint'(epoch_counter), 0);
        chk("rst_araddr", longint'(ARADDR), 0);
        chk("rst_arid", longint'(ARID), 0);
        chk("arlen", longint'(ARLEN), BL - 1);
        chk("arsize", longint'(ARSIZE), 5);
        chk("arburst", longint'(ARBURST), 1);

        for (int i = 0; i < 6; i++) begin
            run_cfg($sformatf("vec%0d", i), vt[i].aa, vt[i].ab, vt[i].dl, vt[i].bl, vt[i].ep,
                    vt[i].mode, vt[i].lat, vt[i].ea, vt[i].eb, vt[i].ee);
        end

        // Multi-epoch run with a start pulse mid-run that must be ignored.
        build_exp(33'h20000, 33'h10000, 512, 200, 3);
        rmode = 1; rlat = 3; resp_en = 1'b1;
        do_start(33'h20000, 33'h10000, 512, 200, 3);
        reached = 1'b0;
        for (int i = 0; i < 500 && !reached; i++) begin
            @(negedge clk);
            if (sb_idx >= 4) reached = 1'b1;
        end
        chk("midstart_progress", longint'(reached), 1);
        do_start(33'h70000, 33'h60000, 4096, 4096, 5);
        wait_done(4000, "midstart");
        chk("midstart_a_cnt", longint'(ar_a_counter), 6);
        chk("midstart_b_cnt", longint'(ar_b_counter), 3);
        chk("midstart_epochs", longint'(epoch_counter), 3);
        repeat (3) @(negedge clk);
        chk("midstart_done_pulses", longint'(done_cnt), 1);
        chk("midstart_ar_total", longint'(sb_idx), 9);
        $display("job midstart: a=%0d b=%0d epochs=%0d", ar_a_counter, ar_b_counter, epoch_counter);

        // Credit stall: no responses, the cap of 4 must hold; each RLAST frees one slot.
        build_exp(33'h4000, 33'h0, 4096, 0, 1);
        rmode = 0; resp_en = 1'b0; noise = 1'b0;
        do_start(33'h4000, 33'h0, 4096, 0, 1);
        repeat (30) @(negedge clk);
        chk("stall_hs", longint'(sb_idx), 4);
        chk("stall_arvalid", longint'(ARVALID), 0);
        chk("stall_out", longint'(outstanding), 4);
        manual_req++;
        repeat (10) @(negedge clk);
        chk("stall_one_more", longint'(sb_idx), 5);
        chk("stall_arvalid2", longint'(ARVALID), 0);
        manual_req++;
        repeat (10) @(negedge clk);
        chk("stall_two_more", longint'(sb_idx), 6);
        $display("credit stall: bursts=%0d outstanding=%0d", sb_idx, outstanding);

        // Reset while ARVALID is high with three bursts in flight.
        rmode = 3;
        repeat (3) @(negedge clk);
        manual_req++;
        repeat (5) @(negedge clk);
        chk("prerst_arvalid", longint'(ARVALID), 1);
        chk("prerst_out", longint'(outstanding), 3);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("rst_mid_arvalid", longint'(ARVALID), 0);
        chk("rst_mid_out", longint'(outstanding), 0);
        chk("rst_mid_busy", longint'(busy), 0);
        chk("rst_mid_a_cnt", longint'(ar_a_counter), 0);
        chk("rst_mid_araddr", longint'(ARADDR), 0);
        @(posedge clk); #3;
        rst = 1'b0;
        rmode = 0;
        $display("reset mid-run: arvalid=%0d outstanding=%0d", ARVALID, outstanding);
        run_cfg("post_reset", vt[0].aa, vt[0].ab, vt[0].dl, vt[0].bl, vt[0].ep,
                0, 4, vt[0].ea, vt[0].eb, vt[0].ee);

        // Randomized jobs against the reference list.
        noise = 1'b1;
        for (int r = 0; r < 8; r++) begin
            ra   = {1'($urandom_range(0, 1)), 32'($urandom)};
            rb   = {1'($urandom_range(0, 1)), 32'($urandom)};
            rdl  = $urandom_range(1, 3000);
            rbl  = $urandom_range(0, 3000);
            rep  = $urandom_range(0, 3);
            reff = (rep == 0) ? 1 : int'(rep);
            rna  = int'((rdl + BB - 1) / BB);
            rnb  = int'((rbl + BB - 1) / BB);
            run_cfg($sformatf("rand%0d", r), ra, rb, rdl, rbl, rep,
                    $urandom_range(0, 2), $urandom_range(1, 8), rna * reff, rnb * reff, reff);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
